// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Multiplexed common-anode seven-segment driver for the stopwatch display.
//   A binary value is accepted over a valid/ready handshake, converted to BCD
//   by a sequential double-dabble engine (one bit per clock), then committed
//   into double-buffered display registers. A free-running prescaler scans
//   the digits with leading-zero blanking, per-digit decimal points, PWM
//   brightness and an overflow (all dashes) indication.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-low
//   value          binary value to display
//   value_valid    value presented (held stable until accepted)
//   value_ready    converter idle; transfer on value_valid && value_ready
//   blank_lz       1 = blank leading zeros
//   dp_mask        decimal point enables, bit i pairs with anode_signals[i]
//   brightness     duty control, all-ones = full on
//   anode_signals  active-low digit enables, MSB = leftmost digit
//   display_out    active-low segments, bit6 = a ... bit0 = g
//   dp_out         active-low decimal point
//   overflow       last committed value exceeded 10^NUM_DIGITS - 1
module seven_segment_scanner #(
    parameter int NUM_DIGITS    = 4,
    parameter int VALUE_WIDTH   = 14,
    parameter int SCAN_DIV_BITS = 16,
    parameter int BRIGHT_BITS   = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic                   value_valid,
    output logic                   value_ready,
    input  logic                   blank_lz,
    input  logic [NUM_DIGITS-1:0]  dp_mask,
    input  logic [BRIGHT_BITS-1:0] brightness,
    output logic [NUM_DIGITS-1:0]  anode_signals,
    output logic [6:0]             display_out,
    output logic                   dp_out,
    output logic                   overflow
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    // Largest value that fits on the display.
    localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

    // Enough BCD nibbles for any VALUE_WIDTH-bit input (log10(2) < 1/3),
    // and never fewer than the number of displayed digits.
    localparam int BIN_DIGITS = (VALUE_WIDTH + 2) / 3;
    localparam int BCD_DIGITS = (BIN_DIGITS > NUM_DIGITS) ? BIN_DIGITS : NUM_DIGITS;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int DISP_W     = 4 * NUM_DIGITS;
    localparam int CNT_W      = $clog2(VALUE_WIDTH + 1);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b1111110;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Converter FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [VALUE_WIDTH-1:0]   bin_sr, bin_nxt;
    logic [BCD_W-1:0]         bcd_sr, bcd_nxt;
    logic [BCD_W-1:0]         bcd_adj;
    logic [BCD_W+VALUE_WIDTH-1:0] dd_shift;
    logic [CNT_W-1:0]         bit_cnt, cnt_nxt;
    logic                     ovf_pend, ovf_nxt;
    logic                     commit;

    // Committed (displayed) copy; only written in COMMIT so an in-flight
    // conversion never disturbs the scan.
    logic [DISP_W-1:0]        disp_bcd;
    logic                     disp_ovf;

    // Double-dabble: add 3 to every nibble >= 5, then shift {bcd, bin}.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
    end

    assign dd_shift = {bcd_adj, bin_sr} << 1;

    always_comb begin
        state_nxt = state;
        bin_nxt   = bin_sr;
        bcd_nxt   = bcd_sr;
        cnt_nxt   = bit_cnt;
        ovf_nxt   = ovf_pend;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (value_valid) begin
                    bin_nxt   = value;
                    bcd_nxt   = '0;
                    cnt_nxt   = CNT_W'(VALUE_WIDTH);
                    ovf_nxt   = (64'(value) > MAX_VAL);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_nxt, bin_nxt} = dd_shift;
                cnt_nxt = bit_cnt - CNT_W'(1);
                if (bit_cnt == CNT_W'(1))
                    state_nxt = COMMIT;
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            bit_cnt  <= '0;
            ovf_pend <= 1'b0;
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
        end else begin
            state    <= state_nxt;
            bin_sr   <= bin_nxt;
            bcd_sr   <= bcd_nxt;
            bit_cnt  <= cnt_nxt;
            ovf_pend <= ovf_nxt;
            if (commit) begin
                disp_bcd <= bcd_sr[DISP_W-1:0];
                disp_ovf <= ovf_pend;
            end
        end
    end

    assign value_ready = (state == IDLE);
    assign overflow    = disp_ovf;

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    // 'running' holds the scan for one clock after reset release, so the
    // prescaler/index start counting together and the first digit lights on
    // the second edge with a full digit period.
    logic                     running;
    logic [SCAN_DIV_BITS-1:0] presc;
    logic [IDX_W-1:0]         dig_idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            running <= 1'b0;
            presc   <= '0;
            dig_idx <= '0;
        end else begin
            running <= 1'b1;
            if (running) begin
                presc <= presc + SCAN_DIV_BITS'(1);
                if (&presc)
                    dig_idx <= (dig_idx == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                                   : dig_idx + IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit selection and segment generation
    // ------------------------------------------------------------------
    // Index 0 is the most significant digit, so it maps to the top nibble
    // and the top anode bit.
    logic [IDX_W-1:0]       pos;
    logic [3:0]             nib;
    logic [NUM_DIGITS-1:0]  lz;
    logic                   seen_nz;
    logic                   bright_on;
    logic [NUM_DIGITS-1:0]  an_nxt;
    logic [6:0]             seg_nxt;
    logic                   dp_nxt;

    assign pos       = IDX_W'(NUM_DIGITS - 1) - dig_idx;
    assign nib       = disp_bcd[4*pos +: 4];
    assign bright_on = (presc[SCAN_DIV_BITS-1 -: BRIGHT_BITS] <= brightness);

    // lz[i] = nibble i sits above the highest non-zero nibble. Nibble 0 is
    // never a leading zero, so a zero value still shows one '0'.
    always_comb begin
        lz      = '0;
        seen_nz = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            seen_nz = seen_nz | (disp_bcd[4*i +: 4] != 4'd0);
            lz[i]   = ~seen_nz;
        end
    end

    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        if (running && bright_on) begin
            an_nxt[pos] = 1'b0;
            dp_nxt      = ~dp_mask[pos];
            if (disp_ovf)
                seg_nxt = SEG_DASH;
            else if (blank_lz && lz[pos])
                seg_nxt = SEG_OFF;
            else
                seg_nxt = seg_decode(nib);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            anode_signals <= '1;
            display_out   <= SEG_OFF;
            dp_out        <= 1'b1;
        end else begin
            anode_signals <= an_nxt;
            display_out   <= seg_nxt;
            dp_out        <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
module tb_seven_segment_scanner;

    localparam int ND   = 4;
    localparam int VW   = 14;
    localparam int SDB  = 4;
    localparam int BB   = 3;
    localparam int PER  = 1 << SDB;   // clocks per digit
    localparam int SPAN = ND * PER;   // clocks per full scan

    localparam logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010,
                                        7'b0000110, 7'b1001100, 7'b0100100,
                                        7'b0100000, 7'b0001111, 7'b0000000,
                                        7'b0000100};
    localparam logic [ND-1:0] AN_SEQ [ND] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [VW-1:0] value = '0;
    logic          value_valid = 1'b0;
    logic          value_ready;
    logic          blank_lz = 1'b0;
    logic [ND-1:0] dp_mask = '1;
    logic [BB-1:0] brightness = '1;
    logic [ND-1:0] anode_signals;
    logic [6:0]    display_out;
    logic          dp_out;
    logic          overflow;

    int checks = 0;
    int failures = 0;

    seven_segment_scanner #(
        .NUM_DIGITS   (ND),
        .VALUE_WIDTH  (VW),
        .SCAN_DIV_BITS(SDB),
        .BRIGHT_BITS  (BB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .value        (value),
        .value_valid  (value_valid),
        .value_ready  (value_ready),
        .blank_lz     (blank_lz),
        .dp_mask      (dp_mask),
        .brightness   (brightness),
        .anode_signals(anode_signals),
        .display_out  (display_out),
        .dp_out       (dp_out),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int p10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    // Time since reset release in edges, a busy countdown for the converter,
    // and the committed integer value; digits come from plain division.
    int ecount = 0;
    int busy = 0;
    int pend_val = 0;
    int disp_val = 0;
    bit mdl_ok = 0;
    logic [ND-1:0] e_an = '1;
    logic [6:0]    e_seg = 7'h7f;
    logic          e_dp = 1'b1;
    logic          e_rdy = 1'b1;
    logic          e_ovf = 1'b0;

    always @(posedge clock) begin : model
        int s, p, top;
        if (!reset) begin
            ecount = 0; busy = 0; disp_val = 0;
            e_an = '1; e_seg = 7'h7f; e_dp = 1'b1;
        end else begin
            ecount++;
            e_an = '1; e_seg = 7'h7f; e_dp = 1'b1;
            if (ecount >= 2) begin
                s   = ecount - 2;
                top = (s % PER) >> (SDB - BB);
                p   = ND - 1 - ((s / PER) % ND);
                if (top <= int'(brightness)) begin
                    e_an[p] = 1'b0;
                    e_dp    = ~dp_mask[p];
                    if (disp_val > p10(ND) - 1)
                        e_seg = 7'b1111110;
                    else if (blank_lz && p > 0 && disp_val < p10(p))
                        e_seg = 7'h7f;
                    else
                        e_seg = SEG[(disp_val / p10(p)) % 10];
                end
            end
            if (busy > 0) begin
                busy--;
                if (busy == 0) disp_val = pend_val;
            end else if (value_valid) begin
                pend_val = int'(value);
                busy     = VW + 1;
            end
        end
        e_rdy  = (busy == 0);
        e_ovf  = (disp_val > p10(ND) - 1);
        mdl_ok = 1;
    end

    always @(negedge clock) begin
        if (mdl_ok) begin
            cmp("anode",    32'(anode_signals), 32'(e_an));
            cmp("segments", 32'(display_out),   32'(e_seg));
            cmp("dp",       32'(dp_out),        32'(e_dp));
            cmp("ready",    32'(value_ready),   32'(e_rdy));
            cmp("overflow", 32'(overflow),      32'(e_ovf));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_phase(input int target);
        int n = 0;
        while (!(ecount >= 2 && ((ecount - 2) % SPAN) == target)) begin
            @(negedge clock);
            n++;
            if (n > 4 * SPAN) begin
                checks++; failures++;
                $display("FAIL wait_phase: timeout after %0d clocks, required phase %0d", n, target);
                return;
            end
        end
    endtask

    // segs = {digit0 (leftmost), digit1, digit2, digit3}
    task automatic scan_pin(input string name, input logic [ND-1:0][6:0] segs);
        repeat (2) @(negedge clock);
        wait_phase(5);
        for (int k = 0; k < ND; k++) begin
            cmp({name, "_an"},  32'(anode_signals), 32'(AN_SEQ[k]));
            cmp({name, "_seg"}, 32'(display_out),   32'(segs[ND-1-k]));
            repeat (PER) @(negedge clock);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!value_ready) begin
            @(negedge clock);
            n++;
            if (n > 100) begin
                checks++; failures++;
                $display("FAIL wait_ready: timeout, got ready 0 required 1");
                return;
            end
        end
    endtask

    task automatic send(input logic [VW-1:0] v);
        int n = 0;
        @(negedge clock);
        wait_ready();
        #2 value = v; value_valid = 1'b1;
        @(negedge clock);
        #2 value_valid = 1'b0;
        while (!value_ready && n < 40) begin
            n++;
            @(negedge clock);
        end
        cmp("ready_low_cycles", 32'(n), 32'(VW + 1));
    endtask

    // Caller is at a negedge.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        cmp("rst_anode", 32'(anode_signals), 32'hf);
        cmp("rst_seg",   32'(display_out),   32'h7f);
        cmp("rst_dp",    32'(dp_out),        32'h1);
        cmp("rst_ready", 32'(value_ready),   32'h1);
        cmp("rst_ovf",   32'(overflow),      32'h0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        cmp("hold1_anode", 32'(anode_signals), 32'hf);
        cmp("hold1_seg",   32'(display_out),   32'h7f);
        @(negedge clock);
        cmp("first_digit", 32'(anode_signals), 32'(4'b0111));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, nb;
        brightness = 3'd7; dp_mask = 4'b1111; blank_lz = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        repeat (40) @(negedge clock);
        do_reset();

        // 1234, no blanking, full brightness
        send(14'd1234);
        scan_pin("v1234", {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100});

        // leading-zero blanking
        #2 blank_lz = 1'b1;
        send(14'd7);
        scan_pin("v7_blank", {7'h7f, 7'h7f, 7'h7f, 7'b0001111});
        #2 blank_lz = 1'b0;
        scan_pin("v7_noblank", {7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111});
        #2 blank_lz = 1'b1;
        send(14'd0);
        scan_pin("v0_blank", {7'h7f, 7'h7f, 7'h7f, 7'b0000001});

        // overflow, then recovery (blanking ignored while overflowed)
        send(14'd12000);
        cmp("ovf_set", 32'(overflow), 32'h1);
        scan_pin("v12000", {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110});
        #2 blank_lz = 1'b0;
        send(14'd42);
        cmp("ovf_clr", 32'(overflow), 32'h0);
        scan_pin("v42", {7'b0000001, 7'b0000001, 7'b1001100, 7'b0010010});

        // brightness duty and decimal point
        #2 brightness = 3'd0;
        repeat (2) @(negedge clock);
        n = 0;
        repeat (SPAN) begin
            @(negedge clock);
            if (anode_signals == 4'b0111) n++;
        end
        cmp("dim_on_clocks", 32'(n), 32'd2);
        #2 brightness = 3'd7; dp_mask = 4'b0100;
        repeat (2) @(negedge clock);
        n = 0; nb = 0;
        repeat (SPAN) begin
            @(negedge clock);
            if (anode_signals == 4'b0111) n++;
            if ((dp_out == 1'b0) != (anode_signals == 4'b1011)) nb++;
        end
        cmp("full_on_clocks", 32'(n), 32'd16);
        cmp("dp_wrong_digit", 32'(nb), 32'd0);

        // value changing while busy: only the captured one shows
        @(negedge clock);
        wait_ready();
        #2 value = 14'd5678; value_valid = 1'b1;
        repeat (10) begin
            @(negedge clock);
            #2 value = VW'($urandom_range(0, 16383));
        end
        value_valid = 1'b0;
        @(negedge clock);
        wait_ready();
        scan_pin("v5678", {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000});

        // reset during the 5th SHIFT cycle of 9999
        @(negedge clock);
        wait_ready();
        #2 value = 14'd9999; value_valid = 1'b1;
        @(negedge clock);
        #2 value_valid = 1'b0;
        repeat (4) @(negedge clock);
        do_reset();
        repeat (40) @(negedge clock);
        cmp("post_rst_ready", 32'(value_ready), 32'h1);
        scan_pin("after_rst", {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001});

        // randomized traffic, checked every cycle by the model
        repeat (60) begin
            brightness = BB'($urandom);
            blank_lz   = 1'($urandom);
            dp_mask    = ND'($urandom);
            case ($urandom_range(0, 3))
                0: value = VW'($urandom_range(0, 9));
                1: value = VW'($urandom_range(0, 999));
                2: value = VW'($urandom_range(0, 9999));
                default: value = VW'($urandom_range(10000, 16383));
            endcase
            value_valid = 1'($urandom);
            repeat ($urandom_range(1, 60)) begin
                @(negedge clock);
                #2;
                if ($urandom_range(0, 3) == 0) value_valid = ~value_valid;
                if ($urandom_range(0, 3) == 0) value = VW'($urandom);
                if ($urandom_range(0, 15) == 0) brightness = BB'($urandom);
            end
        end
        value_valid = 1'b0;
        repeat (SPAN) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Parametrised multiplexed seven-segment display driver for the Stopwatch display path.
- Accepts a binary value through a valid/ready handshake and converts it to BCD with a sequential double-dabble engine.
- Scans NUM_DIGITS common-anode digits, with leading-zero blanking, per-digit decimal points, PWM brightness and overflow indication.
- Sits between the stopwatch counters and the board's anode/cathode pins.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8)
- VALUE_WIDTH, 14, width of binary input value
- SCAN_DIV_BITS, 16, prescaler width; digit period = 2^SCAN_DIV_BITS clocks
- BRIGHT_BITS, 3, brightness control width (must be <= SCAN_DIV_BITS)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- value  in  VALUE_WIDTH  binary value to display
- value_valid  in  1  value presented; must hold value stable until accepted
- value_ready  out  1  converter idle; transfer on value_valid && value_ready at a rising edge
- blank_lz  in  1  1 = blank leading zeros
- dp_mask  in  NUM_DIGITS  decimal point enables, bit i pairs with anode_signals[i]
- brightness  in  BRIGHT_BITS  display duty control, all-ones = full on
- anode_signals  out  NUM_DIGITS  active-low digit enables, MSB = leftmost digit
- display_out  out  7  active-low segments, bit6 = a … bit0 = g
- dp_out  out  1  active-low decimal point
- overflow  out  1  last committed value exceeded 10^NUM_DIGITS − 1

## Operation
- Converter FSM has three states: IDLE, SHIFT and COMMIT.
  - **IDLE:** value_ready = 1. On a handshake, capture value and set the overflow flag := (value > 10^NUM_DIGITS − 1). Clear the BCD shift register to 0, load a bit counter with VALUE_WIDTH, go to SHIFT.
  - **SHIFT:** one double-dabble iteration per clock. Every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1 and the counter decrements. After VALUE_WIDTH iterations go to COMMIT.
  - **COMMIT:** copy the low 4·NUM_DIGITS BCD bits and the overflow flag into the display registers, then go to IDLE.
- value_valid while value_ready = 0 is ignored; no queueing.
- The display registers are double-buffered. Scanning always uses the last committed value, and an in-flight conversion never disturbs the display.
- Scan: an SCAN_DIV_BITS-bit prescaler free-runs. Its terminal count advances the digit index 0 → NUM_DIGITS−1 → 0; the wrap is explicit, not a power-of-two rollover.
- Digit index k drives anode bit NUM_DIGITS−1−k and shows BCD nibble NUM_DIGITS−1−k, so index 0 is the most significant digit.
- Segment encoding: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- Overflow = 1: every digit shows dash 1111110, and blanking is ignored.
- blank_lz = 1: digits more significant than the highest non-zero digit show 1111111. The least significant digit is never blanked.
- dp_out = ~dp_mask[i] while anode i is active; this is independent of blanking and overflow.
- Brightness gating:
  - Anode enabled only while prescaler[SCAN_DIV_BITS−1 -: BRIGHT_BITS] <= brightness.
  - During the gated-off time anode_signals = all ones, display_out = 1111111, dp_out = 1.
  - brightness = 0 gives a duty of 1/2^BRIGHT_BITS.

## Timing
- Reset (asynchronous, any time, including mid-conversion) sets:
  - FSM to IDLE, value_ready = 1, overflow = 0
  - display BCD = 0, prescaler = 0, digit index = 0
  - anode_signals = all ones, display_out = 1111111, dp_out = 1
- An in-flight conversion is discarded on reset.
- anode_signals, display_out and dp_out are registered. They lag the scan index and prescaler by exactly 1 clock. The first digit lights on the second edge after reset release.
- Handshake at edge T: value_ready = 0 from T through T+VALUE_WIDTH. COMMIT is at edge T+VALUE_WIDTH+1, when value_ready returns to 1 and overflow updates.
- Segment outputs reflect the new value at edge T+VALUE_WIDTH+2.
- Minimum spacing between accepted values is VALUE_WIDTH+2 clocks.
- Changes to blank_lz, dp_mask and brightness take effect on the next output register update; they are not gated by the handshake.

## Test plan
Bench uses SCAN_DIV_BITS = 4; all other parameters at defaults.
- Assert reset mid-scan with dp_mask = 1111 → anode_signals = 1111, display_out = 1111111, dp_out = 1, value_ready = 1, overflow = 0, held until 2 edges after release.
- value = 1234, blank_lz = 0, brightness = 7 → value_ready low for 15 cycles, then the scan cycles:
  - 0111/1001111
  - 1011/0010010
  - 1101/0000110
  - 1110/1001100
  - each 16 clocks
- value = 7 with blank_lz = 1 → three digits 1111111, last 0001111. With blank_lz = 0 → 0000001 ×3 then 0001111. value = 0 with blank_lz = 1 → only the rightmost digit shows 0000001.
- value = 12000 → overflow = 1, all four digits 1111110. Then value = 42 → overflow = 0, display shows 0, 0, 4, 2.
- brightness = 0 → each anode low for 2 of its 16 clocks; brightness = 7 → all 16. dp_mask = 0100 → dp_out low only while anode_signals = 1011.
- value_valid held with value changing during busy → only the captured value is displayed. Reset asserted at the 5th SHIFT cycle of value = 9999 → display 0000 after release and value_ready = 1.
